// File: rtl/mem_stage_pkg.sv
// Shared encodings, FSM states and load-extension helper for the wait-state memory stage.
package mem_stage_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10,
      SZ_RSVD = 2'b11
   } mem_size_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      WAIT = 2'b01,
      DONE = 2'b10
   } state_e;

   localparam logic [31:0] BUBBLE_WORD = 32'h0000_0000;
   localparam logic        BUBBLE_FLAG = 1'b0;

   // Right-align the addressed lane of a little-endian word and extend it to 32 bits.
   function automatic logic [31:0] load_extend(input logic [31:0] word,
                                               input logic [1:0]  lane,
                                               input logic [1:0]  size,
                                               input logic        zext);
      logic [31:0] sh;
      sh = word >> {lane, 3'b000};
      case (size)
         SZ_BYTE: return {{24{~zext & sh[7]}}, sh[7:0]};
         SZ_HALF: return {{16{~zext & sh[15]}}, sh[15:0]};
         SZ_WORD: return word;
         default: return BUBBLE_WORD;
      endcase
   endfunction

endpackage

// File: rtl/byte_lane_mem.sv
// Word-organised data memory split into four byte lanes; synchronous masked write, combinational read.
module byte_lane_mem #(
   parameter int DEPTH = 256,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic [3:0]    byte_en,
   input  logic [AW-1:0] idx,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   logic [3:0][7:0] mem_r [DEPTH];

   assign rdata = mem_r[idx];

   // Commit each enabled byte lane; the array is deliberately never reset.
   always_ff @(posedge clk) begin
      for (int l = 0; l < 4; l++) begin
         if (byte_en[l]) begin
            mem_r[idx][l] <= wdata[8*l +: 8];
         end
      end
   end

endmodule

// File: rtl/mem_stage_ws.sv
// Memory pipeline stage with configurable wait states, alignment checking and a MEM/WB register.
module mem_stage_ws
   import mem_stage_pkg::*;
#(
   parameter int DATA_W      = 32,
   parameter int DEPTH       = 256,
   parameter int WAIT_STATES = 0,
   parameter int WB_CTRL_W   = 2,
   parameter int REG_ADDR_W  = 5
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [WB_CTRL_W-1:0]  control_wb,
   input  logic [DATA_W-1:0]     address,
   input  logic [DATA_W-1:0]     write_data,
   input  logic [REG_ADDR_W-1:0] write_register,
   input  logic                  mem_read,
   input  logic                  mem_write,
   input  logic [1:0]            mem_size,
   input  logic                  mem_unsigned,
   input  logic                  flush,
   output logic                  stall_out,
   output logic [WB_CTRL_W-1:0]  control_wb_out,
   output logic [DATA_W-1:0]     read_data_out,
   output logic [DATA_W-1:0]     alu_result_out,
   output logic [REG_ADDR_W-1:0] write_reg_out,
   output logic                  misaligned_out
);

   localparam int         AW       = $clog2(DEPTH);
   localparam logic [2:0] CNT_INIT = 3'(WAIT_STATES - 1);

   state_e                  state_r, state_nxt;
   logic [2:0]              cnt_r, cnt_nxt;
   logic                    access_s, misaligned_s, valid_s;
   logic                    stall_s, bubble_s, complete_s, we_s;
   logic [3:0]              be_s;
   logic [31:0]             wlane_s, rdata_s, read_ext_s;
   logic [WB_CTRL_W-1:0]    cwb_nxt;
   logic [REG_ADDR_W-1:0]   reg_nxt;
   logic [DATA_W-1:0]       alu_nxt, rd_nxt;
   logic                    mis_nxt;
   logic                    unused_addr_s;

   assign unused_addr_s = ^address[DATA_W-1:AW+2];
   assign access_s      = mem_read | mem_write;
   assign valid_s       = access_s & ~misaligned_s;
   assign we_s          = complete_s & mem_write & RST;
   assign read_ext_s    = load_extend(rdata_s, address[1:0], mem_size, mem_unsigned);

   // Alignment check and store lane steering.
   always_comb begin
      misaligned_s = 1'b1;
      wlane_s      = 32'h0000_0000;
      be_s         = 4'b0000;
      case (mem_size)
         SZ_BYTE: begin
            misaligned_s = 1'b0;
            wlane_s      = {4{write_data[7:0]}};
            be_s         = 4'b0001 << address[1:0];
         end
         SZ_HALF: begin
            misaligned_s = address[0];
            wlane_s      = {2{write_data[15:0]}};
            be_s         = address[1] ? 4'b1100 : 4'b0011;
         end
         SZ_WORD: begin
            misaligned_s = address[1] | address[0];
            wlane_s      = write_data[31:0];
            be_s         = 4'b1111;
         end
         default: begin
            misaligned_s = 1'b1;
            wlane_s      = 32'h0000_0000;
            be_s         = 4'b0000;
         end
      endcase
   end

   byte_lane_mem #(.DEPTH(DEPTH)) u_mem (
      .clk     (CLK),
      .byte_en (be_s & {4{we_s}}),
      .idx     (address[AW+1:2]),
      .wdata   (wlane_s),
      .rdata   (rdata_s)
   );

   // Wait-state sequencing; cnt counts the remaining stall cycles including the current one.
   always_comb begin
      state_nxt  = state_r;
      cnt_nxt    = cnt_r;
      stall_s    = 1'b0;
      bubble_s   = 1'b0;
      complete_s = 1'b0;
      if (flush) begin
         state_nxt = IDLE;
         cnt_nxt   = 3'd0;
         bubble_s  = 1'b1;
      end else begin
         case (state_r)
            IDLE: begin
               if (!valid_s) begin
                  state_nxt = IDLE;
               end else if (WAIT_STATES == 0) begin
                  complete_s = 1'b1;
               end else begin
                  stall_s   = 1'b1;
                  bubble_s  = 1'b1;
                  cnt_nxt   = CNT_INIT;
                  state_nxt = (WAIT_STATES == 1) ? DONE : WAIT;
               end
            end
            WAIT: begin
               stall_s  = 1'b1;
               bubble_s = 1'b1;
               if (cnt_r <= 3'd1) begin
                  state_nxt = DONE;
                  cnt_nxt   = 3'd0;
               end else begin
                  cnt_nxt = cnt_r - 3'd1;
               end
            end
            DONE: begin
               complete_s = 1'b1;
               state_nxt  = IDLE;
            end
            default: begin
               state_nxt = IDLE;
               cnt_nxt   = 3'd0;
            end
         endcase
      end
   end

   // Combinational stall, forced low while reset is held.
   always_comb begin
      stall_out = stall_s & RST;
   end

   // MEM/WB next-value selection: bubble, misalignment record or normal record.
   always_comb begin
      cwb_nxt = control_wb;
      reg_nxt = write_register;
      alu_nxt = address;
      rd_nxt  = {DATA_W{1'b0}};
      mis_nxt = 1'b0;
      if (bubble_s) begin
         cwb_nxt = {WB_CTRL_W{1'b0}};
         reg_nxt = {REG_ADDR_W{1'b0}};
         alu_nxt = BUBBLE_WORD;
         rd_nxt  = BUBBLE_WORD;
         mis_nxt = BUBBLE_FLAG;
      end else if ((state_r == IDLE) && access_s && misaligned_s) begin
         cwb_nxt = {WB_CTRL_W{1'b0}};
         reg_nxt = {REG_ADDR_W{1'b0}};
         mis_nxt = 1'b1;
      end else if (complete_s && mem_read && !mem_write) begin
         rd_nxt = read_ext_s;
      end else begin
         rd_nxt = {DATA_W{1'b0}};
      end
   end

   // FSM state and wait counter.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_r <= IDLE;
         cnt_r   <= 3'd0;
      end else begin
         state_r <= state_nxt;
         cnt_r   <= cnt_nxt;
      end
   end

   // MEM/WB pipeline register.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         control_wb_out <= {WB_CTRL_W{1'b0}};
         write_reg_out  <= {REG_ADDR_W{1'b0}};
         alu_result_out <= {DATA_W{1'b0}};
         read_data_out  <= {DATA_W{1'b0}};
         misaligned_out <= 1'b0;
      end else begin
         control_wb_out <= cwb_nxt;
         write_reg_out  <= reg_nxt;
         alu_result_out <= alu_nxt;
         read_data_out  <= rd_nxt;
         misaligned_out <= mis_nxt;
      end
   end

endmodule

// File: tb/tb_mem_stage_ws.sv
// Directed bench: three stage instances with 0, 3 and 2 wait states checked against hand-computed values.
module tb_mem_stage_ws;

   logic clk;
   logic rst_n;

   logic [1:0]  cwb  [3];
   logic [31:0] addr [3];
   logic [31:0] wdat [3];
   logic [4:0]  wreg [3];
   logic        rd   [3];
   logic        wr   [3];
   logic [1:0]  sz   [3];
   logic        uns  [3];
   logic        fl   [3];

   wire         stall [3];
   wire [1:0]   cwb_o [3];
   wire [31:0]  rdo   [3];
   wire [31:0]  alu_o [3];
   wire [4:0]   wr_o  [3];
   wire         mis_o [3];

   int n_cmp;
   int n_err;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      mem_stage_ws #(
         .DATA_W      (32),
         .DEPTH       (256),
         .WAIT_STATES (g == 0 ? 0 : (g == 1 ? 3 : 2)),
         .WB_CTRL_W   (2),
         .REG_ADDR_W  (5)
      ) u_dut (
         .CLK            (clk),
         .RST            (rst_n),
         .control_wb     (cwb[g]),
         .address        (addr[g]),
         .write_data     (wdat[g]),
         .write_register (wreg[g]),
         .mem_read       (rd[g]),
         .mem_write      (wr[g]),
         .mem_size       (sz[g]),
         .mem_unsigned   (uns[g]),
         .flush          (fl[g]),
         .stall_out      (stall[g]),
         .control_wb_out (cwb_o[g]),
         .read_data_out  (rdo[g]),
         .alu_result_out (alu_o[g]),
         .write_reg_out  (wr_o[g]),
         .misaligned_out (mis_o[g])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1);
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input int i, input logic r, input logic w, input logic [1:0] s,
                         input logic u, input logic [31:0] a, input logic [31:0] d,
                         input logic [4:0] rg, input logic [1:0] c);
      rd[i]   = r;
      wr[i]   = w;
      sz[i]   = s;
      uns[i]  = u;
      addr[i] = a;
      wdat[i] = d;
      wreg[i] = rg;
      cwb[i]  = c;
      fl[i]   = 1'b0;
      #1;
   endtask

   task automatic set_nop(input int i);
      set_op(i, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 5'd0, 2'b00);
   endtask

   // Runs one access to completion; every stalled cycle must register a bubble.
   task automatic run_access(input int i, output int cyc, output int stl);
      cyc = 0;
      stl = 0;
      while (cyc < 20) begin
         if (stall[i]) begin
            stl++;
            step();
            cyc++;
            check_val("bubble_alu", alu_o[i], 32'h0);
         end else begin
            step();
            cyc++;
            break;
         end
      end
   endtask

   initial begin
      int c1, c2, s1, s2;
      n_cmp = 0;
      n_err = 0;
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         rd[i] = 1'b0; wr[i] = 1'b0; sz[i] = 2'b00; uns[i] = 1'b0;
         addr[i] = 32'h0; wdat[i] = 32'h0; wreg[i] = 5'd0; cwb[i] = 2'b00; fl[i] = 1'b0;
      end
      #12;
      check_val("rst_rd", rdo[0], 32'h0);
      check_val("rst_alu", alu_o[0], 32'h0);
      check_val("rst_mis", {31'h0, mis_o[0]}, 32'h0);
      check_val("rst_stall", {31'h0, stall[1]}, 32'h0);
      rst_n = 1'b1;
      step();

      // zero wait states
      set_op(0, 1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 5'd0, 2'b00);
      check_val("ws0_sw_stall", {31'h0, stall[0]}, 32'h0);
      step();
      check_val("ws0_sw_rd", rdo[0], 32'h0);
      check_val("ws0_sw_alu", alu_o[0], 32'h10);
      set_op(0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 5'd7, 2'b11);
      check_val("ws0_lw_stall", {31'h0, stall[0]}, 32'h0);
      step();
      check_val("ws0_lw", rdo[0], 32'hDEADBEEF);
      check_val("ws0_lw_cwb", {30'h0, cwb_o[0]}, 32'h3);
      check_val("ws0_lw_reg", {27'h0, wr_o[0]}, 32'h7);
      set_op(0, 1'b1, 1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 5'd7, 2'b11);
      step();
      check_val("lb_13", rdo[0], 32'hFFFFFFDE);
      set_op(0, 1'b1, 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 5'd7, 2'b11);
      step();
      check_val("lbu_13", rdo[0], 32'h000000DE);
      set_op(0, 1'b1, 1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 5'd7, 2'b11);
      step();
      check_val("lh_12", rdo[0], 32'hFFFFDEAD);

      // misalignment
      set_op(0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h12, 32'h0, 5'd7, 2'b11);
      check_val("mis_stall", {31'h0, stall[0]}, 32'h0);
      step();
      check_val("mis_lw", {31'h0, mis_o[0]}, 32'h1);
      check_val("mis_cwb", {30'h0, cwb_o[0]}, 32'h0);
      check_val("mis_reg", {27'h0, wr_o[0]}, 32'h0);
      check_val("mis_alu", alu_o[0], 32'h12);
      check_val("mis_rd", rdo[0], 32'h0);
      set_op(0, 1'b0, 1'b1, 2'b10, 1'b0, 32'h12, 32'h11111111, 5'd0, 2'b11);
      step();
      check_val("mis_sw", {31'h0, mis_o[0]}, 32'h1);
      set_op(0, 1'b1, 1'b0, 2'b11, 1'b0, 32'h0, 32'h0, 5'd7, 2'b11);
      step();
      check_val("mis_rsvd", {31'h0, mis_o[0]}, 32'h1);
      set_op(0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h55, 32'h0, 5'd3, 2'b10);
      step();
      check_val("nop_mis", {31'h0, mis_o[0]}, 32'h0);
      check_val("nop_alu", alu_o[0], 32'h55);
      check_val("nop_cwb", {30'h0, cwb_o[0]}, 32'h2);
      set_op(0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 5'd7, 2'b11);
      step();
      check_val("mis_mem_kept", rdo[0], 32'hDEADBEEF);

      // read+write together is a store; sizes and address wrap
      set_op(0, 1'b1, 1'b1, 2'b10, 1'b0, 32'h8, 32'h00000077, 5'd7, 2'b11);
      step();
      check_val("rw_rd", rdo[0], 32'h0);
      set_op(0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h8, 32'h0, 5'd7, 2'b11);
      step();
      check_val("rw_mem", rdo[0], 32'h00000077);
      set_op(0, 1'b0, 1'b1, 2'b10, 1'b0, 32'h0, 32'hCAFEF00D, 5'd0, 2'b00);
      step();
      set_op(0, 1'b0, 1'b1, 2'b01, 1'b0, 32'h402, 32'hFFFF1234, 5'd0, 2'b00);
      step();
      set_op(0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 5'd7, 2'b11);
      step();
      check_val("sh_wrap", rdo[0], 32'h1234F00D);
      set_op(0, 1'b0, 1'b1, 2'b00, 1'b0, 32'h1, 32'hFFFFFF5A, 5'd0, 2'b00);
      step();
      set_op(0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 5'd7, 2'b11);
      step();
      check_val("sb_lane1", rdo[0], 32'h12345A0D);
      set_op(0, 1'b1, 1'b0, 2'b01, 1'b1, 32'h2, 32'h0, 5'd7, 2'b11);
      step();
      check_val("lhu_2", rdo[0], 32'h00001234);

      // three wait states
      set_op(1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 5'd0, 2'b00);
      run_access(1, c1, s1);
      check_val("ws3_sw_stalls", 32'(s1), 32'd3);
      check_val("ws3_sw_rd", rdo[1], 32'h0);
      set_op(1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 5'd9, 2'b01);
      run_access(1, c2, s2);
      check_val("ws3_lw_stalls", 32'(s2), 32'd3);
      check_val("ws3_total", 32'(c1 + c2), 32'd8);
      check_val("ws3_lw", rdo[1], 32'hDEADBEEF);
      check_val("ws3_lw_reg", {27'h0, wr_o[1]}, 32'h9);
      check_val("ws3_lw_cwb", {30'h0, cwb_o[1]}, 32'h1);
      set_nop(1);

      // flush during WAIT with two wait states
      set_op(2, 1'b0, 1'b1, 2'b00, 1'b0, 32'h20, 32'h00000033, 5'd0, 2'b00);
      run_access(2, c1, s1);
      check_val("ws2_init_stalls", 32'(s1), 32'd2);
      set_op(2, 1'b0, 1'b1, 2'b00, 1'b0, 32'h20, 32'h000000AA, 5'd0, 2'b11);
      check_val("fl_c1_stall", {31'h0, stall[2]}, 32'h1);
      step();
      fl[2] = 1'b1;
      #1;
      check_val("fl_c2_stall", {31'h0, stall[2]}, 32'h0);
      step();
      check_val("fl_bub_cwb", {30'h0, cwb_o[2]}, 32'h0);
      check_val("fl_bub_mis", {31'h0, mis_o[2]}, 32'h0);
      set_op(2, 1'b1, 1'b0, 2'b00, 1'b1, 32'h20, 32'h0, 5'd4, 2'b11);
      run_access(2, c1, s1);
      check_val("fl_lbu_stalls", 32'(s1), 32'd2);
      check_val("fl_lbu_old", rdo[2], 32'h00000033);

      // asynchronous reset in the middle of a store
      set_op(2, 1'b0, 1'b1, 2'b10, 1'b0, 32'h24, 32'h01020304, 5'd0, 2'b00);
      run_access(2, c1, s1);
      set_op(2, 1'b0, 1'b1, 2'b10, 1'b0, 32'h24, 32'h99999999, 5'd0, 2'b00);
      step();
      #2;
      rst_n = 1'b0;
      #1;
      check_val("arst_stall", {31'h0, stall[2]}, 32'h0);
      check_val("arst_rd0", rdo[0], 32'h0);
      check_val("arst_alu0", alu_o[0], 32'h0);
      check_val("arst_cwb0", {30'h0, cwb_o[0]}, 32'h0);
      set_nop(2);
      rst_n = 1'b1;
      set_op(2, 1'b1, 1'b0, 2'b10, 1'b0, 32'h24, 32'h0, 5'd5, 2'b11);
      run_access(2, c1, s1);
      check_val("arst_stalls", 32'(s1), 32'd2);
      check_val("arst_no_commit", rdo[2], 32'h01020304);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
